// File: rtl/riscv_dmem_if_pkg.sv
// Shared definitions for the memory-stage data interface: endianness selectors,
// access-size encodings (funct3[1:0]) and the bus FSM state encoding.
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif
`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif

package riscv_dmem_if_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/riscv_dmem_if_lane.sv
// Byte-lane steering for a data-memory access: byte enables, lane-replicated
// store data and the misaligned/illegal-size flag.
module riscv_dmem_lane
    import riscv_dmem_if_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]              addr,
    input  logic [1:0]              size,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic                    align_err
);

    localparam int NB = DATA_WIDTH / 8;

    logic [1:0] first_lane;
    logic [1:0] second_lane;

    // A halfword occupies the addressed lane plus its neighbour; big-endian
    // mirrors both lanes around the word.
    always_comb begin
        be          = '0;
        wdata       = wr_data;
        align_err   = 1'b0;
        first_lane  = BIG_ENDIAN ? 2'd3 - addr : addr;
        second_lane = BIG_ENDIAN ? 2'd2 - addr : addr + 2'd1;
        case (size_e'(size))
            SIZE_BYTE: begin
                be[first_lane] = 1'b1;
                wdata          = {NB{wr_data[7:0]}};
            end
            SIZE_HALF: begin
                be[first_lane]  = 1'b1;
                be[second_lane] = 1'b1;
                wdata           = {(NB/2){wr_data[15:0]}};
                align_err       = addr[0];
            end
            SIZE_WORD: begin
                be        = '1;
                align_err = |addr;
            end
            default: begin
                align_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_dmem_if.sv
// Memory-stage data interface: runs the req/gnt/rvalid bus handshake, stalls the
// pipeline while an access is outstanding and aborts accesses that time out.
module riscv_dmem_if
    import riscv_dmem_if_pkg::*;
#(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_ADDR_WIDTH = 32,
    parameter int MP_ENDIANESS  = `RISCV_BIG_ENDIAN,
    parameter int MP_TIMEOUT    = 16
) (
    input  logic                       iclk,
    input  logic                       irst,
    input  logic                       ird_en,
    input  logic                       iwr_en,
    input  logic [MP_ADDR_WIDTH-1:0]   iaddr,
    input  logic [1:0]                 isize,
    input  logic [MP_DATA_WIDTH-1:0]   iwr_data,
    output logic [MP_DATA_WIDTH-1:0]   ordata,
    output logic                       ostall,
    output logic                       oaccess_err,
    output logic                       otimeout,
    output logic                       obus_req,
    output logic                       obus_we,
    output logic [MP_ADDR_WIDTH-1:0]   obus_addr,
    output logic [MP_DATA_WIDTH/8-1:0] obus_be,
    output logic [MP_DATA_WIDTH-1:0]   obus_wdata,
    input  logic                       ibus_gnt,
    input  logic                       ibus_rvalid,
    input  logic [MP_DATA_WIDTH-1:0]   ibus_rdata
);

    localparam int BE_W  = MP_DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MP_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MP_TIMEOUT - 2);

    state_e                   state;
    logic [CNT_W-1:0]         cnt;
    logic                     access;
    logic                     align_err;
    logic [BE_W-1:0]          lane_be;
    logic [MP_DATA_WIDTH-1:0] lane_wdata;

    assign access = ird_en | iwr_en;

    riscv_dmem_lane #(
        .DATA_WIDTH (MP_DATA_WIDTH),
        .BIG_ENDIAN (MP_ENDIANESS == `RISCV_BIG_ENDIAN)
    ) u_lane (
        .addr      (iaddr[1:0]),
        .size      (isize),
        .wr_data   (iwr_data),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .align_err (align_err)
    );

    always_comb begin
        ostall      = 1'b0;
        oaccess_err = 1'b0;
        case (state)
            IDLE: begin
                ostall      = access & ~align_err;
                oaccess_err = access & align_err;
            end
            REQ, RESP: ostall = 1'b1;
            default:   ostall = 1'b0;
        endcase
    end

    // The counter keeps running across REQ and RESP, so the budget covers the
    // whole access; reaching CNT_LAST+1 without the awaited event aborts it.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state      <= IDLE;
            cnt        <= '0;
            ordata     <= '0;
            otimeout   <= 1'b0;
            obus_req   <= 1'b0;
            obus_we    <= 1'b0;
            obus_addr  <= '0;
            obus_be    <= '0;
            obus_wdata <= '0;
        end else begin
            otimeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !align_err) begin
                        obus_addr  <= {iaddr[MP_ADDR_WIDTH-1:2], 2'b00};
                        obus_be    <= lane_be;
                        obus_we    <= iwr_en;
                        obus_wdata <= lane_wdata;
                        obus_req   <= 1'b1;
                        cnt        <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (ibus_gnt) begin
                        obus_req <= 1'b0;
                        state    <= obus_we ? DONE : RESP;
                    end else if (cnt >= CNT_LAST) begin
                        obus_req <= 1'b0;
                        otimeout <= 1'b1;
                        if (!obus_we) begin
                            ordata <= '0;
                        end
                        state <= DONE;
                    end
                end
                RESP: begin
                    cnt <= cnt + 1'b1;
                    if (ibus_rvalid) begin
                        ordata <= ibus_rdata;
                        state  <= DONE;
                    end else if (cnt >= CNT_LAST) begin
                        otimeout <= 1'b1;
                        ordata   <= '0;
                        state    <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_if.sv
// Self-checking bench for riscv_dmem_if: directed vector table plus randomized
// accesses scored against a closed-form model, on a big- and a little-endian instance.
module tb_riscv_dmem_if;

    typedef struct {
        logic        le;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        int          gd;
        int          rdl;
        logic [31:0] rdat;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_err;
        int          exp_stall;
        logic        exp_to;
    } vec_t;

    localparam int T_BIG    = 16;
    localparam int T_LITTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wr_data;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        sel;

    logic [31:0] b_rdata, l_rdata, o_rdata;
    logic        b_stall, l_stall, o_stall;
    logic        b_err, l_err, o_err;
    logic        b_to, l_to, o_to;
    logic        b_req, l_req, o_req;
    logic        b_we, l_we, o_we;
    logic [31:0] b_addr, l_addr, o_addr;
    logic [3:0]  b_ben, l_ben, o_ben;
    logic [31:0] b_wdata, l_wdata, o_wdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] held;
    vec_t        vecs[13];

    always #5 clk = ~clk;

    riscv_dmem_if #(
        .MP_DATA_WIDTH (32),
        .MP_ADDR_WIDTH (32),
        .MP_ENDIANESS  (`RISCV_BIG_ENDIAN),
        .MP_TIMEOUT    (T_BIG)
    ) dut_big (
        .iclk(clk), .irst(rst), .ird_en(rd_en), .iwr_en(wr_en), .iaddr(addr),
        .isize(size), .iwr_data(wr_data), .ordata(b_rdata), .ostall(b_stall),
        .oaccess_err(b_err), .otimeout(b_to), .obus_req(b_req), .obus_we(b_we),
        .obus_addr(b_addr), .obus_be(b_ben), .obus_wdata(b_wdata),
        .ibus_gnt(gnt), .ibus_rvalid(rvalid), .ibus_rdata(rdata)
    );

    riscv_dmem_if #(
        .MP_DATA_WIDTH (32),
        .MP_ADDR_WIDTH (32),
        .MP_ENDIANESS  (`RISCV_LITTLE_ENDIAN),
        .MP_TIMEOUT    (T_LITTLE)
    ) dut_little (
        .iclk(clk), .irst(rst), .ird_en(rd_en), .iwr_en(wr_en), .iaddr(addr),
        .isize(size), .iwr_data(wr_data), .ordata(l_rdata), .ostall(l_stall),
        .oaccess_err(l_err), .otimeout(l_to), .obus_req(l_req), .obus_we(l_we),
        .obus_addr(l_addr), .obus_be(l_ben), .obus_wdata(l_wdata),
        .ibus_gnt(gnt), .ibus_rvalid(rvalid), .ibus_rdata(rdata)
    );

    assign o_rdata = sel ? l_rdata : b_rdata;
    assign o_stall = sel ? l_stall : b_stall;
    assign o_err   = sel ? l_err   : b_err;
    assign o_to    = sel ? l_to    : b_to;
    assign o_req   = sel ? l_req   : b_req;
    assign o_we    = sel ? l_we    : b_we;
    assign o_addr  = sel ? l_addr  : b_addr;
    assign o_ben   = sel ? l_ben   : b_ben;
    assign o_wdata = sel ? l_wdata : b_wdata;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveIdle();
        rd_en = 1'b0; wr_en = 1'b0; addr = '0; size = '0; wr_data = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stall"}, 32'(o_stall), 32'd0);
        checkOutput({tag, "_err"},   32'(o_err),   32'd0);
        checkOutput({tag, "_to"},    32'(o_to),    32'd0);
        checkOutput({tag, "_req"},   32'(o_req),   32'd0);
        checkOutput({tag, "_we"},    32'(o_we),    32'd0);
        checkOutput({tag, "_addr"},  o_addr,       32'd0);
        checkOutput({tag, "_be"},    32'(o_ben),   32'd0);
        checkOutput({tag, "_wdata"}, o_wdata,      32'd0);
        checkOutput({tag, "_rdata"}, o_rdata,      32'd0);
    endtask

    task automatic doReset(input logic which);
        @(posedge clk); #1;
        sel = which;
        rst = 1'b1;
        driveIdle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");
        held = '0;
    endtask

    // Reference model: lane choice and replication straight from the byte-lane rules.
    function automatic logic [3:0] modelBe(input logic le, input logic [31:0] a, input logic [1:0] s);
        int k;
        int lane;
        k = int'(a[1:0]);
        lane = le ? k : 3 - k;
        case (s)
            2'd0:    return 4'(1 << lane);
            2'd1:    return le ? 4'((1 << (k + 1)) | (1 << k)) : 4'((1 << (3 - k)) | (1 << (2 - k)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] s, input logic [31:0] d);
        case (s)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic modelErr(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    endfunction

    // Cycle budget: the access may spend up to T-1 cycles in REQ+RESP, one more
    // if the grant arrives right at the limit and the load then waits for data.
    function automatic void modelTiming(input int t, input logic load, input int gd, input int rdl,
                                        output int stall, output logic to);
        int p;
        int r;
        to = 1'b0;
        if (gd > t - 2) begin
            stall = t;
            to    = 1'b1;
        end else if (!load) begin
            stall = gd + 2;
        end else begin
            p = (t - 2 > gd + 1) ? t - 2 : gd + 1;
            r = gd + 1 + rdl;
            if (r > p) begin
                stall = p + 2;
                to    = 1'b1;
            end else begin
                stall = r + 2;
            end
        end
    endfunction

    function automatic vec_t makeRandom(input logic le);
        vec_t v;
        v.le   = le;
        v.rd   = 1'($urandom_range(0, 1));
        v.wr   = ~v.rd;
        v.addr = $urandom;
        v.size = 2'($urandom_range(0, 3));
        v.data = $urandom;
        v.gd   = $urandom_range(0, 4);
        v.rdl  = $urandom_range(0, 4);
        v.rdat = $urandom;
        v.exp_err   = modelErr(v.addr, v.size);
        v.exp_be    = v.exp_err ? 4'h0 : modelBe(le, v.addr, v.size);
        v.exp_wdata = modelWdata(v.size, v.data);
        modelTiming(le ? T_LITTLE : T_BIG, v.rd, v.gd, v.rdl, v.exp_stall, v.exp_to);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        int gc;
        int rc;
        int done;
        int nstall;
        logic [31:0] exp_rd;
        if (v.exp_err) begin
            @(posedge clk); #1;
            rd_en = v.rd; wr_en = v.wr; addr = v.addr; size = v.size; wr_data = v.data;
            gnt = 1'b0; rvalid = 1'($urandom_range(0, 1)); rdata = $urandom;
            @(negedge clk);
            checkOutput("err_pulse", 32'(o_err),   32'd1);
            checkOutput("err_stall", 32'(o_stall), 32'd0);
            checkOutput("err_req",   32'(o_req),   32'd0);
            @(posedge clk); #1;
            driveIdle();
            @(negedge clk);
            checkOutput("err_clear",  32'(o_err), 32'd0);
            checkOutput("err_noreq",  32'(o_req), 32'd0);
            checkOutput("err_rdata",  o_rdata,    held);
            return;
        end
        gc     = 1 + v.gd;
        rc     = gc + 1 + v.rdl;
        done   = v.exp_stall;
        nstall = 0;
        exp_rd = v.rd ? (v.exp_to ? 32'd0 : v.rdat) : held;
        for (int c = 0; c <= done; c++) begin
            @(posedge clk); #1;
            rd_en = v.rd; wr_en = v.wr; addr = v.addr; size = v.size; wr_data = v.data;
            gnt    = (c == gc) || ((c == 0 || c > gc) && 1'($urandom_range(0, 1)));
            rvalid = v.rd ? ((c == rc) || (c <= gc && 1'($urandom_range(0, 1))))
                          : 1'($urandom_range(0, 1));
            rdata  = (c == rc) ? v.rdat : $urandom;
            @(negedge clk);
            if (o_stall) nstall++;
            checkOutput("req", 32'(o_req), 32'(c >= 1 && c <= gc && c < done));
            if (c == 0) begin
                checkOutput("idle_err",   32'(o_err), 32'd0);
                checkOutput("idle_to",    32'(o_to),  32'd0);
                checkOutput("held_rdata", o_rdata,    held);
            end
            if (c == 1) begin
                checkOutput("bus_addr",  o_addr,      {v.addr[31:2], 2'b00});
                checkOutput("bus_be",    32'(o_ben),  32'(v.exp_be));
                checkOutput("bus_we",    32'(o_we),   32'(v.wr));
                checkOutput("bus_wdata", o_wdata,     v.exp_wdata);
            end
            if (c < done) begin
                checkOutput("stall_hi", 32'(o_stall), 32'd1);
            end else begin
                checkOutput("done_stall", 32'(o_stall), 32'd0);
                checkOutput("done_to",    32'(o_to),    32'(v.exp_to));
                checkOutput("done_rdata", o_rdata,      exp_rd);
            end
        end
        checkOutput("stall_cycles", 32'(nstall), 32'(v.exp_stall));
        held = exp_rd;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t rv;
        rst = 1'b0;
        sel = 1'b0;
        held = '0;
        driveIdle();
        //          le    rd    wr    addr        sz    data          gd  rdl rdat          be       wdata         err   stall to
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h202, 2'd1, 32'h0000_1234, 0,  0, 32'h0,        4'b0011, 32'h1234_1234, 1'b0, 2, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h200, 2'd1, 32'h0000_5678, 0,  0, 32'h0,        4'b1100, 32'h5678_5678, 1'b0, 2, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h040, 2'd2, 32'h0,         2,  3, 32'hDEADBEEF, 4'b1111, 32'h0,         1'b0, 8, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h042, 2'd2, 32'h0,         0,  0, 32'h0,        4'b0000, 32'h0,         1'b1, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h041, 2'd1, 32'h0,         0,  0, 32'h0,        4'b0000, 32'h0,         1'b1, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h010, 2'd3, 32'h0,         0,  0, 32'h0,        4'b0000, 32'h0,         1'b1, 0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h001, 2'd0, 32'h0,         0,  1, 32'h0000_0055, 4'b0100, 32'h0,        1'b0, 4, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h006, 2'd0, 32'h0000_01C7, 1,  0, 32'h0,        4'b0010, 32'hC7C7_C7C7, 1'b0, 3, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h103, 2'd0, 32'h0000_00AB, 0,  0, 32'h0,        4'b1000, 32'hABAB_ABAB, 1'b0, 2, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h001, 2'd0, 32'h0,         0,  0, 32'h1122_3344, 4'b0010, 32'h0,        1'b0, 3, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h080, 2'd2, 32'h0,         99, 0, 32'h0,        4'b1111, 32'h0,         1'b0, 4, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h082, 2'd1, 32'h0000_BEEF, 0,  0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 1'b0, 2, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h084, 2'd2, 32'h0BAD_F00D, 5,  0, 32'h0,        4'b1111, 32'h0BAD_F00D, 1'b0, 4, 1'b1};

        doReset(1'b0);
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].le != sel) doReset(vecs[i].le);
            applyStimulus(vecs[i]);
        end

        // Reset in RESP abandons the load; a late rvalid must not reach ordata.
        doReset(1'b0);
        rv = '{1'b0, 1'b1, 1'b0, 32'h048, 2'd2, 32'h0, 0, 0, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 3, 1'b0};
        applyStimulus(rv);
        @(posedge clk); #1;
        rd_en = 1'b1; wr_en = 1'b0; addr = 32'h44; size = 2'd2; gnt = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        checkOutput("mrst_idle_stall", 32'(o_stall), 32'd1);
        @(posedge clk); #1;
        gnt = 1'b1;
        @(negedge clk);
        checkOutput("mrst_req", 32'(o_req), 32'd1);
        @(posedge clk); #1;
        gnt = 1'b0;
        @(negedge clk);
        checkOutput("mrst_resp_stall", 32'(o_stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checkAllZero("mrst");
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        checkOutput("mrst_stale_rdata", o_rdata, 32'd0);
        checkOutput("mrst_stale_stall", 32'(o_stall), 32'd0);
        held = '0;
        rv = '{1'b0, 1'b1, 1'b0, 32'h003, 2'd0, 32'h0, 0, 0, 32'h0000_0077, 4'b0001, 32'h0, 1'b0, 3, 1'b0};
        applyStimulus(rv);

        for (int s = 0; s < 2; s++) begin
            doReset(1'(s));
            for (int n = 0; n < 40; n++) begin
                rv = makeRandom(1'(s));
                applyStimulus(rv);
            end
        end

        @(posedge clk); #1;
        driveIdle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
